color_matrix_ctrl: RTL
======================

COLOR_MATRIX_CTRL -- requirements
Module: color_matrix_ctrl

Interface
REQ-001 Parameter DSIZE, default 8, pixel component width.
REQ-002 Parameter MSIZE, default 8, coefficient width (sign-magnitude: bit MSIZE-1 sign, MSIZE-2:0 magnitude).
REQ-003 Parameter LAT, default 4, matrix datapath latency in cycles, input to Ro/Go/Bo.
REQ-004 clock  in  1  single clock, all logic rising-edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 cfg_we  in  1  config write strobe.
REQ-007 cfg_addr  in  4  0..8 coefficient index k=row*3+col; 9 commit; 10..15 ignored.
REQ-008 cfg_wdata  in  MSIZE  coefficient value.
REQ-009 cfg_busy  out  1  commit pending, not yet applied.
REQ-010 in_vsync, in_hsync, in_de  in  1 each  video timing aligned with pixel fed to datapath.
REQ-011 m_coef  out  9*MSIZE  active bank to datapath, element k at [k*MSIZE +: MSIZE].
REQ-012 dp_R, dp_G, dp_B  in  DSIZE+1 each  datapath results.
REQ-013 out_vsync, out_hsync, out_de  out  1 each  timing aligned to out_R/G/B.
REQ-014 out_R, out_G, out_B  out  DSIZE each  clamped results.

Function
REQ-015 Shadow bank: cfg_we with cfg_addr 0..8 SHALL write cfg_wdata to shadow[k] at the clock edge, in any FSM state.
REQ-016 FSM SHALL have states IDLE and PENDING; cfg_busy=1 only in PENDING.
REQ-017 IDLE -> PENDING on cfg_we with cfg_addr=9; commit in PENDING SHALL be ignored.
REQ-018 vsync rising edge SHALL be detected from a registered copy of in_vsync (edge = in_vsync & ~vsync_q).
REQ-019 In PENDING, on the cycle an edge is detected, the shadow bank SHALL be copied to the active bank (m_coef valid next cycle) and the FSM SHALL return to IDLE.
REQ-020 Commit and edge in the same cycle from IDLE: FSM enters PENDING; swap waits for the next edge.
REQ-021 Shadow write and swap in the same cycle: active bank receives the pre-write shadow; new value stays in shadow.
REQ-022 m_coef SHALL change only at a swap or reset, never mid-frame.
REQ-023 Timing delay line: in_vsync/hsync/de SHALL be delayed LAT+1 cycles (LAT for datapath, 1 for clamp register).
REQ-024 Clamp: out_X = 2^DSIZE-1 if dp_X[DSIZE]=1, else dp_X[DSIZE-1:0], registered.
REQ-025 out_R/G/B SHALL be forced to 0 when the delayed de is 0.
REQ-026 End-to-end latency in_* to out_* SHALL be exactly LAT+1 cycles.

Reset
REQ-027 On reset, active and shadow banks SHALL load identity: k=0,4,8 -> 2^(MSIZE-1)-1 (0x7F), others 0.
REQ-028 On reset, FSM -> IDLE, cfg_busy=0, vsync_q=0, delay line cleared, out_* = 0.
REQ-029 Reset during PENDING SHALL discard the pending commit; no swap occurs.

Structure
REQ-030 Shared package SHALL hold the commit address (9), the identity constant, and the FSM state encoding.
REQ-031 A single sub-module, timing_delay_line (parameterised width and depth), SHALL implement REQ-023.
REQ-032 The datapath SHALL be instantiated outside this block; the block SHALL contain no multipliers.

Verification
REQ-033 After reset, R=G=B=200 with de=1 -> out_R=out_G=out_B=198 (200*127>>7) and out_de=1 exactly 5 cycles later.
REQ-034 Write k=0..8 values, commit mid-frame -> cfg_busy=1, m_coef unchanged until the cycle after the next vsync rise; then new bank, cfg_busy=0.
REQ-035 Commit coincident with vsync rise -> no swap at that edge; swap at the following vsync rise.
REQ-036 dp_R=9'h1A5 with delayed de=1 -> out_R=8'hFF; dp_R=9'h0A5 -> 8'hA5; delayed de=0 -> out_R=0.
REQ-037 Commit, then reset before vsync -> cfg_busy=0, identity bank retained across the next vsync.
REQ-038 Shadow write to k=4 in the swap cycle -> active[4] holds the old shadow value; the next commit plus vsync applies the new value.

Source files
------------

// File: rtl/color_matrix_ctrl_pkg.sv
// color_matrix_ctrl_pkg
//   Shared definitions for the colour-matrix control block: the config
//   address that commits the shadow bank, the FSM state encoding, the video
//   timing bundle and the identity coefficient helper used at reset.
package color_matrix_ctrl_pkg;

   localparam int         NUM_COEF   = 9;
   localparam logic [3:0] CFG_COMMIT = 4'd9;

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_PENDING = 1'b1;

   typedef struct packed {
      logic vsync;
      logic hsync;
      logic de;
   } vid_timing_t;

   // Identity matrix in sign-magnitude: largest positive magnitude on the
   // diagonal (k = 0, 4, 8), zero elsewhere.
   function automatic int unsigned identity_coef(input int k, input int msize);
      return (k == 0 || k == 4 || k == 8) ? (32'd1 << (msize - 1)) - 32'd1 : 32'd0;
   endfunction

endpackage

// File: rtl/color_matrix_ctrl_if.sv
// color_matrix_ctrl_if
//   Coefficient configuration bus.
//   cfg_we    : write strobe
//   cfg_addr  : 0..8 coefficient index (row*3+col), 9 commit, 10..15 ignored
//   cfg_wdata : coefficient value (sign-magnitude, MSIZE bits)
//   cfg_busy  : commit pending, waiting for the next vsync rise
interface color_matrix_ctrl_if #(parameter int MSIZE = 8) ();

   logic             cfg_we;
   logic [3:0]       cfg_addr;
   logic [MSIZE-1:0] cfg_wdata;
   logic             cfg_busy;

   modport master (output cfg_we, output cfg_addr, output cfg_wdata, input cfg_busy);
   modport slave  (input cfg_we, input cfg_addr, input cfg_wdata, output cfg_busy);

endinterface

// File: rtl/color_matrix_ctrl_delay.sv
// timing_delay_line
//   Plain shift register delaying a WIDTH-bit bundle by DEPTH cycles,
//   cleared by synchronous reset.
//   clock, reset : single clock, synchronous active-high reset
//   din / dout   : bundle in / bundle delayed DEPTH cycles
module timing_delay_line #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [DEPTH-1:0][WIDTH-1:0] pipe;

   always_ff @(posedge clock) begin
      if (reset) begin
         pipe <= '0;
      end else begin
         pipe[0] <= din;
         for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/color_matrix_ctrl.sv
// color_matrix_ctrl
//   Control wrapper around an external 3x3 colour-matrix datapath.
//   Holds a shadow and an active coefficient bank; a commit is armed by a
//   config write and applied only at the next vsync rising edge, so the
//   datapath never sees a bank change mid-frame. Also delays the video
//   timing to match the datapath and clamps / blanks its results.
//   clock, reset          : single clock, synchronous active-high reset
//   cfg                   : configuration bus (slave side)
//   in_vsync/hsync/de     : timing aligned with the pixel entering the datapath
//   m_coef                : active bank, element k at [k*MSIZE +: MSIZE]
//   dp_R/G/B              : datapath results (bit DSIZE = overflow)
//   out_vsync/hsync/de    : timing aligned to out_R/G/B
//   out_R/G/B             : clamped, de-blanked results
module color_matrix_ctrl
   import color_matrix_ctrl_pkg::*;
#(
   parameter int DSIZE = 8,
   parameter int MSIZE = 8,
   parameter int LAT   = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   color_matrix_ctrl_if.slave    cfg,
   input  logic                  in_vsync,
   input  logic                  in_hsync,
   input  logic                  in_de,
   output logic [9*MSIZE-1:0]    m_coef,
   input  logic [DSIZE:0]        dp_R,
   input  logic [DSIZE:0]        dp_G,
   input  logic [DSIZE:0]        dp_B,
   output logic                  out_vsync,
   output logic                  out_hsync,
   output logic                  out_de,
   output logic [DSIZE-1:0]      out_R,
   output logic [DSIZE-1:0]      out_G,
   output logic [DSIZE-1:0]      out_B
);

   logic [MSIZE-1:0] shadow [NUM_COEF];
   logic [MSIZE-1:0] active [NUM_COEF];
   logic [0:0]       state;
   logic             vsync_q;
   logic             vs_edge;
   logic             swap;
   logic             commit;

   assign vs_edge      = in_vsync & ~vsync_q;
   assign swap         = (state == ST_PENDING) && vs_edge;
   assign commit       = cfg.cfg_we && (cfg.cfg_addr == CFG_COMMIT);
   assign cfg.cfg_busy = (state == ST_PENDING);

   // Shadow writes and the swap share one edge: active takes the shadow
   // contents as they were before that edge's write.
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= ST_IDLE;
         vsync_q <= 1'b0;
         for (int k = 0; k < NUM_COEF; k++) begin
            shadow[k] <= MSIZE'(identity_coef(k, MSIZE));
            active[k] <= MSIZE'(identity_coef(k, MSIZE));
         end
      end else begin
         vsync_q <= in_vsync;
         if (cfg.cfg_we && cfg.cfg_addr < CFG_COMMIT)
            shadow[cfg.cfg_addr] <= cfg.cfg_wdata;
         if (swap)
            for (int k = 0; k < NUM_COEF; k++) active[k] <= shadow[k];
         case (state)
            ST_IDLE:    if (commit)  state <= ST_PENDING;  // edge in same cycle is not used
            ST_PENDING: if (vs_edge) state <= ST_IDLE;     // further commits ignored
            default:    state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      m_coef = '0;
      for (int k = 0; k < NUM_COEF; k++) m_coef[k*MSIZE +: MSIZE] = active[k];
   end

   vid_timing_t tin, tdly;
   assign tin = '{vsync: in_vsync, hsync: in_hsync, de: in_de};

   timing_delay_line #(
      .WIDTH ($bits(vid_timing_t)),
      .DEPTH (LAT)
   ) u_dly (
      .clock (clock),
      .reset (reset),
      .din   (tin),
      .dout  (tdly)
   );

   function automatic logic [DSIZE-1:0] clamp(input logic [DSIZE:0] v);
      return v[DSIZE] ? {DSIZE{1'b1}} : v[DSIZE-1:0];
   endfunction

   // Final register stage: one cycle on top of the datapath latency.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_vsync <= 1'b0;
         out_hsync <= 1'b0;
         out_de    <= 1'b0;
         out_R     <= '0;
         out_G     <= '0;
         out_B     <= '0;
      end else begin
         out_vsync <= tdly.vsync;
         out_hsync <= tdly.hsync;
         out_de    <= tdly.de;
         out_R     <= tdly.de ? clamp(dp_R) : '0;
         out_G     <= tdly.de ? clamp(dp_G) : '0;
         out_B     <= tdly.de ? clamp(dp_B) : '0;
      end
   end

endmodule
